// File: rtl/rv_lsu.sv
// Load/store unit: byte/half/word accesses to a word-wide data memory with optional
// word-crossing split access, enabled by defining LSU_MISALIGN_EN (otherwise rejected with resp_err).
module rv_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_is_store,
    input  logic [1:0]  req_size,
    input  logic        req_is_signed,
    output logic [31:0] dmem_addr_Q103H,
    output logic [31:0] dmem_wr_data_Q103H,
    output logic        dmem_wr_en_Q103H,
    output logic [3:0]  dmem_byte_en_Q103H,
    output logic        dmem_is_signed_Q103H,
    input  logic [31:0] dmem_rd_data_Q104H,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err
);

`ifdef LSU_MISALIGN_EN
    localparam logic MISALIGN_EN = 1'b1;
`else
    localparam logic MISALIGN_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, ACC0, ACC1, WAIT, RESP} state_t;

    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? 2'b10 : size;
    endfunction

    function automatic logic crosses_word(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return off == 2'd3;
            default: return off != 2'd0;
        endcase
    endfunction

    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << off;
    endfunction

    function automatic logic [63:0] lane_data(input logic [31:0] wdata, input logic [1:0] off);
        return {32'h0, wdata} << {off, 3'b000};
    endfunction

    function automatic logic [31:0] extend_load(input logic [63:0] pair, input logic [1:0] size,
                                                input logic [1:0] off, input logic sgn);
        logic [31:0] sh;
        sh = 32'(pair >> {off, 3'b000});
        case (size)
            2'b00:   return {{24{sgn & sh[7]}}, sh[7:0]};
            2'b01:   return {{16{sgn & sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q, data0_q;
    logic [1:0]  size_q;
    logic        store_q, signed_q, split_q;
    logic        accept, req_split;
    logic [31:0] src_addr, src_wdata;
    logic [1:0]  src_size;
    logic        src_store;
    logic [7:0]  src_mask;
    logic [63:0] src_lanes;
    logic [31:0] addr_nxt, wr_data_nxt, load_result;
    logic [3:0]  be_nxt;
    logic        wr_en_nxt;

    assign req_ready            = (state == IDLE);
    assign resp_valid           = (state == RESP);
    assign dmem_is_signed_Q103H = 1'b0;
    assign accept               = req_valid && req_ready;
    assign req_split            = crosses_word(norm_size(req_size), req_addr[1:0]);

    // The first access is launched on the accept edge, so it is built from the live request.
    assign src_addr  = (state == IDLE) ? req_addr : addr_q;
    assign src_wdata = (state == IDLE) ? req_wdata : wdata_q;
    assign src_size  = (state == IDLE) ? norm_size(req_size) : size_q;
    assign src_store = (state == IDLE) ? req_is_store : store_q;
    assign src_mask  = lane_mask(src_size, src_addr[1:0]);
    assign src_lanes = lane_data(src_wdata, src_addr[1:0]);

    // In WAIT the newest word is on the read bus; for a split load it is the high word.
    assign load_result = extend_load(split_q ? {dmem_rd_data_Q104H, data0_q}
                                             : {32'h0, dmem_rd_data_Q104H},
                                     size_q, addr_q[1:0], signed_q);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (req_split && !MISALIGN_EN) ? RESP : ACC0;
            ACC0: state_nxt = split_q ? ACC1 : (store_q ? RESP : WAIT);
            ACC1: state_nxt = store_q ? RESP : WAIT;
            WAIT: state_nxt = RESP;
            RESP: if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        addr_nxt    = 32'h0;
        wr_data_nxt = 32'h0;
        wr_en_nxt   = 1'b0;
        be_nxt      = 4'h0;
        if (state_nxt == ACC0) begin
            addr_nxt    = {src_addr[31:2], 2'b00};
            wr_en_nxt   = src_store;
            be_nxt      = src_store ? src_mask[3:0] : 4'hF;
            wr_data_nxt = src_store ? src_lanes[31:0] : 32'h0;
        end else if (state_nxt == ACC1) begin
            addr_nxt    = {src_addr[31:2], 2'b00} + 32'd4;
            wr_en_nxt   = src_store;
            be_nxt      = src_store ? src_mask[7:4] : 4'hF;
            wr_data_nxt = src_store ? src_lanes[63:32] : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            dmem_addr_Q103H    <= 32'h0;
            dmem_wr_data_Q103H <= 32'h0;
            dmem_wr_en_Q103H   <= 1'b0;
            dmem_byte_en_Q103H <= 4'h0;
            resp_data          <= 32'h0;
            resp_err           <= 1'b0;
        end else begin
            state              <= state_nxt;
            dmem_addr_Q103H    <= addr_nxt;
            dmem_wr_data_Q103H <= wr_data_nxt;
            dmem_wr_en_Q103H   <= wr_en_nxt;
            dmem_byte_en_Q103H <= be_nxt;
            // Only a rejected request jumps straight from IDLE into RESP.
            if (state != RESP && state_nxt == RESP) begin
                resp_data <= (state == WAIT) ? load_result : 32'h0;
                resp_err  <= (state == IDLE);
            end else if (state == RESP && resp_ready) begin
                resp_data <= 32'h0;
                resp_err  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            size_q   <= norm_size(req_size);
            store_q  <= req_is_store;
            signed_q <= req_is_signed;
            split_q  <= req_split;
        end
        if (state == ACC1) data0_q <= dmem_rd_data_Q104H;
    end

endmodule
